// File: rtl/qed_commit_tracker.sv
// -----------------------------------------------------------------------------
// qed_commit_tracker
//   Follows retiring original/duplicate instructions of an SQED stream.
//   Marks the consistency point T_C (sif_commit_pulsed), keeps the sticky
//   sif_commit flag, counts original and duplicate commits since T_C and raises
//   qed_check_valid whenever both counts match.
//
//   Optional feature macro: QED_SIF_REARM_EN
//     defined   : a matched window in TRACK can be closed with qed_rearm
//                 (only in a cycle without a commit) to open a fresh window.
//     undefined : one window per reset; qed_rearm is ignored.
// -----------------------------------------------------------------------------
module qed_commit_tracker #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sif_en,
  input  logic             commit_valid,
  input  logic             commit_dup,
  input  logic             qed_rearm,
  output logic [1:0]       sif_state,
  output logic             sif_commit,
  output logic             sif_commit_pulsed,
  output logic [CNT_W-1:0] qed_num_orig,
  output logic [CNT_W-1:0] qed_num_dup,
  output logic             qed_check_valid,
  output logic             qed_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRACK = 2'd1,
    S_ERROR = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic             commit_q, commit_d;
  logic [CNT_W-1:0] orig_q, orig_d;
  logic [CNT_W-1:0] dup_q, dup_d;
  logic             err_q, err_d;

  logic orig_c;
  logic dup_c;
  logic counts_match;
  logic check_valid;
  logic rearm_req;

  assign orig_c       = commit_valid & ~commit_dup;
  assign dup_c        = commit_valid &  commit_dup;
  assign counts_match = (orig_q == dup_q);

`ifdef QED_SIF_REARM_EN
  // A rearm request competes with a commit; the commit always wins.
  assign rearm_req = qed_rearm & ~commit_valid;
`else
  logic unused_rearm;
  assign unused_rearm = qed_rearm;
  assign rearm_req    = 1'b0;
`endif

  // Combinational markers, forced low while reset is being applied.
  always_comb begin
    sif_commit_pulsed = ~rst & (state_q == S_IDLE) & sif_en & orig_c;
    check_valid       = ~rst & (state_q == S_TRACK) & counts_match & (orig_q != '0);
  end

  // Next-state and counter update for the tracking window.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d  = state_q;
    commit_d = commit_q;
    orig_d   = orig_q;
    dup_d    = dup_q;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE: begin
        // Duplicates in IDLE and commits with sif_en low are ignored.
        if (sif_en && orig_c) begin
          state_d  = S_TRACK;
          commit_d = 1'b1;
          orig_d   = {{(CNT_W-1){1'b0}}, 1'b1};
          dup_d    = '0;
        end
      end
      S_TRACK: begin
        if (rearm_req && check_valid) begin
          state_d  = S_IDLE;
          commit_d = 1'b0;
          orig_d   = '0;
          dup_d    = '0;
        end else if (orig_c) begin
          if (orig_q == CNT_MAX) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end else begin
            orig_d = orig_q + 1'b1;
          end
        end else if (dup_c) begin
          // A duplicate that would overtake its original is a protocol error.
          if (counts_match) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end else begin
            dup_d = dup_q + 1'b1;
          end
        end
      end
      S_ERROR: begin
        // Absorbing until reset; everything holds.
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q  <= S_IDLE;
      commit_q <= 1'b0;
      orig_q   <= '0;
      dup_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      commit_q <= commit_d;
      orig_q   <= orig_d;
      dup_q    <= dup_d;
      err_q    <= err_d;
    end
  end

  assign sif_state       = state_q;
  assign sif_commit      = commit_q;
  assign qed_num_orig    = orig_q;
  assign qed_num_dup     = dup_q;
  assign qed_check_valid = check_valid;
  assign qed_err         = err_q;

endmodule
